// File: rtl/exec_shift_arb_if.sv
// Handshake bundle for exec_shift_arb: two requester ports and one result port.
// The master side drives requests and out_ready; the slave side is the arbiter.
interface exec_shift_arb_if #(
  parameter int unsigned W_OPR   = 32,
  parameter int unsigned W_FLAGS = 4
);
  logic               req0_valid;
  logic               req0_ready;
  logic [W_OPR-1:0]   req0_opr0;
  logic [W_OPR-1:0]   req0_opr1;
  logic [1:0]         req0_sel;

  logic               req1_valid;
  logic               req1_ready;
  logic [W_OPR-1:0]   req1_opr0;
  logic [W_OPR-1:0]   req1_opr1;
  logic [1:0]         req1_sel;

  logic               out_valid;
  logic               out_ready;
  logic               out_tag;
  logic [W_OPR-1:0]   out_result;
  logic [W_FLAGS-1:0] out_flags;

  modport master (
    output req0_valid, req0_opr0, req0_opr1, req0_sel,
    output req1_valid, req1_opr0, req1_opr1, req1_sel,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_tag, out_result, out_flags
  );

  modport slave (
    input  req0_valid, req0_opr0, req0_opr1, req0_sel,
    input  req1_valid, req1_opr0, req1_opr1, req1_sel,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_tag, out_result, out_flags
  );
endinterface

// File: rtl/exec_shift_arb.sv
// Round-robin arbiter sharing one shifter between two requesters, with a single
// registered result stage tagged by the winning requester.
module exec_shift_arb #(
  parameter int unsigned W_OPR   = 32,
  parameter int unsigned W_FLAGS = 4
) (
  input logic            clk,
  input logic            rst,
  exec_shift_arb_if.slave bus
);

  localparam int unsigned ShW = $clog2(W_OPR);

  logic               out_valid_q;
  logic               out_tag_q;
  logic [W_OPR-1:0]   out_result_q;
  logic [W_FLAGS-1:0] out_flags_q;
  logic               last_grant_q;

  logic               can_accept;
  logic               grant;
  logic               accept;
  logic               ready0;
  logic               ready1;

  logic [W_OPR-1:0]   opr0;
  logic [W_OPR-1:0]   opr1;
  logic [1:0]         sel;
  logic [ShW-1:0]     amt;
  logic [2*W_OPR-1:0] wide;
  logic [W_OPR-1:0]   result;
  logic               carry;
  logic               zero;
  logic               sign;
  logic               overflow;
  logic [W_FLAGS-1:0] flags;
  logic               unused_opr1;

  assign can_accept = !out_valid_q || bus.out_ready;

  // Contention goes to whoever did not win the last accepted transfer.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = !last_grant_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign ready0 = can_accept && !grant && bus.req0_valid;
  assign ready1 = can_accept && grant && bus.req1_valid;
  assign accept = ready0 || ready1;

  assign opr0 = grant ? bus.req1_opr0 : bus.req0_opr0;
  assign opr1 = grant ? bus.req1_opr1 : bus.req0_opr1;
  assign sel  = grant ? bus.req1_sel  : bus.req0_sel;
  assign amt  = opr1[ShW-1:0];

  assign unused_opr1 = ^opr1[W_OPR-1:ShW];

  // Double-width shift: one half is the result, the other holds the bits shifted out.
  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    unique case (sel)
      2'd0: begin
        wide   = {{W_OPR{1'b0}}, opr0} << amt;
        result = wide[W_OPR-1:0];
        carry  = |wide[2*W_OPR-1:W_OPR];
      end
      2'd1: begin
        wide   = {opr0, {W_OPR{1'b0}}} >> amt;
        result = wide[2*W_OPR-1:W_OPR];
        carry  = |wide[W_OPR-1:0];
      end
      2'd2: begin
        wide   = $unsigned($signed({opr0, {W_OPR{1'b0}}}) >>> amt);
        result = wide[2*W_OPR-1:W_OPR];
        carry  = |wide[W_OPR-1:0];
      end
      2'd3: begin
        result = '0;
        carry  = 1'b0;
      end
      default: ;
    endcase
    zero     = ~|result;
    sign     = result[W_OPR-1];
    overflow = opr0[W_OPR-1] ^ sign;
    flags    = W_FLAGS'({overflow, sign, zero, carry});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_tag_q    <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_tag_q    <= grant;
      out_result_q <= result;
      out_flags_q  <= flags;
      last_grant_q <= grant;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;

endmodule

// File: tb/tb_exec_shift_arb.sv
// Scoreboard bench for exec_shift_arb: a predictor models arbitration and shifting,
// a separate monitor compares every presented result against the queued expectation.
module tb_exec_shift_arb;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
  } op_t;

  typedef struct packed {
    logic        tag;
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_shift_arb_if #(.W_OPR(W), .W_FLAGS(4)) bus ();

  exec_shift_arb #(.W_OPR(W), .W_FLAGS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t sb[$];
  op_t  cur0;
  op_t  cur1;
  bit   v0, v1, took0, took1;
  bit   m_full = 1'b0;
  bit   m_last = 1'b1;
  bit   ord;
  int unsigned valid_pct = 100;
  int unsigned ready_pct = 100;
  int   ready_mode = 1;  // 0 random, 1 always high, 2 always low
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
    op_t o;
    o.a = a;
    o.b = b;
    o.sel = s;
    return o;
  endfunction

  // Bit-at-a-time reference of the shift rules.
  function automatic exp_t model(input op_t o, input logic tag);
    exp_t e;
    int n;
    logic [31:0] r;
    logic c;
    n = int'(o.b[4:0]);
    r = '0;
    c = 1'b0;
    case (o.sel)
      2'd0: begin
        r = o.a << n;
        for (int i = 0; i < n; i++) c |= o.a[31-i];
      end
      2'd1: begin
        r = o.a >> n;
        for (int i = 0; i < n; i++) c |= o.a[i];
      end
      2'd2: begin
        r = o.a >> n;
        if (o.a[31]) for (int i = 0; i < n; i++) r[31-i] = 1'b1;
        for (int i = 0; i < n; i++) c |= o.a[i];
      end
      default: ;
    endcase
    e.tag = tag;
    e.res = r;
    e.flags = {o.a[31] ^ r[31], r[31], (r == 32'd0), c};
    return e;
  endfunction

  // Predictor: decides who should be accepted this cycle and queues the expected result.
  always @(negedge clk) begin
    bit cana, g, e0, e1;
    #1;
    if (rst) begin
      sb.delete();
      m_full = 1'b0;
      m_last = 1'b1;
      took0 = 1'b0;
      took1 = 1'b0;
    end else begin
      cana = !m_full || bus.out_ready;
      g = (v0 && v1) ? !m_last : v1;
      e0 = cana && v0 && !g;
      e1 = cana && v1 && g;
      check("req0_ready", 64'(bus.req0_ready), 64'(e0));
      check("req1_ready", 64'(bus.req1_ready), 64'(e1));
      took0 = bus.req0_ready && v0;
      took1 = bus.req1_ready && v1;
      if (e0 || e1) begin
        sb.push_back(model(g ? cur1 : cur0, g));
        m_full = 1'b1;
        m_last = g;
      end else if (bus.out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("out_valid_spurious", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb[0];
          check("out_tag", 64'(bus.out_tag), 64'(e.tag));
          check("out_result", 64'(bus.out_result), 64'(e.res));
          check("out_flags", 64'(bus.out_flags), 64'(e.flags));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end else if (sb.size() != 0) begin
        check("out_valid_missing", 64'(bus.out_valid), 64'd1);
      end
    end
  end

  task automatic drive();
    bus.req0_valid = v0;
    bus.req0_opr0  = cur0.a;
    bus.req0_opr1  = cur0.b;
    bus.req0_sel   = cur0.sel;
    bus.req1_valid = v1;
    bus.req1_opr0  = cur1.a;
    bus.req1_opr1  = cur1.b;
    bus.req1_sel   = cur1.sel;
    bus.out_ready  = ord;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (v0 && took0) v0 = 1'b0;
    if (v1 && took1) v1 = 1'b0;
    took0 = 1'b0;
    took1 = 1'b0;
    if (!v0 && pend0.size() > 0 && $urandom_range(99) < valid_pct) begin
      cur0 = pend0.pop_front();
      v0 = 1'b1;
    end
    if (!v1 && pend1.size() > 0 && $urandom_range(99) < valid_pct) begin
      cur1 = pend1.pop_front();
      v1 = 1'b1;
    end
    case (ready_mode)
      0: ord = ($urandom_range(99) < ready_pct);
      1: ord = 1'b1;
      default: ord = 1'b0;
    endcase
    drive();
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      step();
      if (pend0.size() == 0 && pend1.size() == 0 && !v0 && !v1 && sb.size() == 0 &&
          !bus.out_valid) done = 1'b1;
    end
    if (!done) check({"idle_timeout_", name}, 64'd0, 64'd1);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_out_tag"}, 64'(bus.out_tag), 64'd0);
    check({name, "_out_result"}, 64'(bus.out_result), 64'd0);
    check({name, "_out_flags"}, 64'(bus.out_flags), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cur0 = '0;
    cur1 = '0;
    v0 = 1'b0;
    v1 = 1'b0;
    ord = 1'b0;
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Directed single-requester operations.
    ready_mode = 1;
    valid_pct = 100;
    pend0.push_back(mk(32'h0000_0001, 32'd4, 2'd0));
    wait_idle("dir0", 20);
    pend1.push_back(mk(32'hFFFF_FFFF, 32'd4, 2'd0));
    wait_idle("dir1", 20);
    pend0.push_back(mk(32'h8000_0000, 32'h3F, 2'd1));
    pend0.push_back(mk(32'h8000_0000, 32'd4, 2'd2));
    pend0.push_back(mk(32'h1234_5678, 32'd7, 2'd3));
    pend1.push_back(mk(32'hF000_000F, 32'd0, 2'd2));
    wait_idle("dir2", 40);

    // Both requesters streaming, consumer always ready: alternating, no bubbles.
    for (int i = 0; i < 8; i++) begin
      pend0.push_back(mk($urandom, $urandom, 2'($urandom_range(3))));
      pend1.push_back(mk($urandom, $urandom, 2'($urandom_range(3))));
    end
    wait_idle("stream", 60);

    // Three-cycle stall with both requesters waiting.
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(mk($urandom, $urandom, 2'($urandom_range(3))));
      pend1.push_back(mk($urandom, $urandom, 2'($urandom_range(3))));
    end
    repeat (3) step();
    ready_mode = 2;
    repeat (3) step();
    ready_mode = 1;
    wait_idle("stall", 60);

    // Randomized traffic with random consumer back-pressure.
    valid_pct = 60;
    ready_mode = 0;
    ready_pct = 70;
    for (int i = 0; i < 150; i++) begin
      pend0.push_back(mk($urandom, $urandom, 2'($urandom_range(3))));
      pend1.push_back(mk(($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom, $urandom,
                         2'($urandom_range(3))));
    end
    wait_idle("random", 5000);

    // Reset while a result is held.
    valid_pct = 100;
    ready_mode = 2;
    pend0.push_back(mk(32'hDEAD_BEEF, 32'd3, 2'd1));
    for (int i = 0; i < 20 && !bus.out_valid; i++) step();
    check("held_before_reset", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    pend0.delete();
    pend1.delete();
    drive();
    step();
    rst = 1'b0;
    check_reset_state("midreset");
    ready_mode = 1;
    pend0.push_back(mk(32'h0000_00FF, 32'd8, 2'd0));
    pend1.push_back(mk(32'hFF00_0000, 32'd8, 2'd2));
    wait_idle("after_reset", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
